// File: rtl/alu_operand_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_operand_sequencer                                      |
// | Description : Gathers A, B and sel from switches over three button       |
// |               presses, drives the ALU, then latches its result/flags.    |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module alu_operand_sequencer #(
  parameter int N      = 4,
  parameter int MAX_OP = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] sw,
  input  logic         btn,
  input  logic [N-1:0] alu_result,
  input  logic         alu_of,
  input  logic         alu_carry,
  input  logic         alu_cero,
  input  logic         alu_neg,
  output logic [N-1:0] A,
  output logic [N-1:0] B,
  output logic [3:0]   sel,
  output logic [N-1:0] res_q,
  output logic [3:0]   flags_q,
  output logic [2:0]   state,
  output logic         done,
  output logic         err
);

  localparam logic [2:0] S_A    = 3'd0;
  localparam logic [2:0] S_B    = 3'd1;
  localparam logic [2:0] S_OP   = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_SHOW = 3'd4;

  localparam logic [4:0] C_OP_LIMIT = 5'(MAX_OP);

  logic [2:0]   state_q, state_d;
  logic         btn_q;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic [3:0]   sel_q, sel_d;
  logic [N-1:0] res_d;
  logic [3:0]   flags_d;
  logic         done_q, done_d;
  logic         err_q, err_d;

  logic         w_press;
  logic         w_op_invalid;

  assign w_press      = btn & ~btn_q;
  assign w_op_invalid = ({1'b0, sw[3:0]} > C_OP_LIMIT);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    res_d   = res_q;
    flags_d = flags_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      S_A: begin
        if (w_press) begin
          a_d     = sw;
          state_d = S_B;
        end
      end
      S_B: begin
        if (w_press) begin
          b_d     = sw;
          state_d = S_OP;
        end
      end
      S_OP: begin
        if (w_press) begin
          sel_d = sw[3:0];
          // Rejected codes skip execution so the previous result stays on display
          if (w_op_invalid) begin
            err_d   = 1'b1;
            state_d = S_SHOW;
          end else begin
            err_d   = 1'b0;
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        res_d   = alu_result;
        flags_d = {alu_of, alu_carry, alu_cero, alu_neg};
        done_d  = 1'b1;
        state_d = S_SHOW;
      end
      S_SHOW: begin
        if (w_press) begin
          state_d = S_A;
        end
      end
      default: begin
        state_d = S_A;
      end
    endcase
  end

  // btn_q resets high so a button held across reset release is not a press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_A;
      btn_q   <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      btn_q   <= btn;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign A     = a_q;
  assign B     = b_q;
  assign sel   = sel_q;
  assign state = state_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_alu_operand_sequencer                                   |
// | Description : Self-checking bench with a behavioural ALU and sequencer   |
// |               reference model.                                           |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_alu_operand_sequencer;

  logic       clk;
  logic       rst;
  logic [3:0] sw;
  logic       btn;
  logic [3:0] alu_result;
  logic       alu_of, alu_carry, alu_cero, alu_neg;
  logic [3:0] A, B, sel, res_q, flags_q;
  logic [2:0] state;
  logic       done, err;

  int errors = 0;
  int checks = 0;

  // Reference copies of what the sequencer should be holding
  logic [3:0] exp_res, exp_flags;

  alu_operand_sequencer #(.N(4), .MAX_OP(9)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn(btn),
    .alu_result(alu_result), .alu_of(alu_of), .alu_carry(alu_carry),
    .alu_cero(alu_cero), .alu_neg(alu_neg),
    .A(A), .B(B), .sel(sel), .res_q(res_q), .flags_q(flags_q),
    .state(state), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: returns {OF, carry, cero, neg, result}
  function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] op);
    int         s;
    logic [3:0] r;
    logic       c, o;
    c = 1'b0;
    o = 1'b0;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: r = a ^ b;
      4'd3: begin
        s = int'(a) + int'(b);
        r = s[3:0];
        c = (s > 15);
        o = (a[3] == b[3]) && (r[3] != a[3]);
      end
      4'd4: begin
        s = int'(a) + int'(~b) + 1;
        r = s[3:0];
        c = (s > 15);
        o = (a[3] != b[3]) && (r[3] != a[3]);
      end
      4'd5: r = ~a;
      4'd6: r = a << 1;
      4'd7: r = a >> 1;
      4'd8: r = a;
      4'd9: r = ~(a & b);
      default: r = 4'hF;
    endcase
    return {o, c, (r == 4'd0), r[3], r};
  endfunction

  always_comb begin
    logic [7:0] v;
    v = alu_f(A, B, sel);
    {alu_of, alu_carry, alu_cero, alu_neg, alu_result} = v;
  end

  task automatic press(input logic [3:0] v);
    @(negedge clk);
    sw  = v;
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sw = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    btn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst       = 1'b0;
    exp_res   = 4'd0;
    exp_flags = 4'd0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({A, B, sel, res_q, flags_q, done, err} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs: got A=%h B=%h sel=%h res=%h flags=%h done=%b err=%b, want all 0",
               A, B, sel, res_q, flags_q, done, err);
    end
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d want 0", state);
    end
  endtask

  task automatic test_and();
    press(4'b1010);
    press(4'b1100);
    press(4'b0000);
    checks++;
    if ({A, B, sel} !== {4'b1010, 4'b1100, 4'b0000}) begin
      errors++;
      $display("FAIL and_operands: got A=%b B=%b sel=%b want 1010 1100 0000", A, B, sel);
    end
    checks++;
    if (state !== 3'd3 || done !== 1'b0 || res_q !== 4'd0) begin
      errors++;
      $display("FAIL and_exec_cycle: got state=%0d done=%b res=%b want 3 0 0000", state, done, res_q);
    end
    @(negedge clk);
    checks++;
    if (res_q !== 4'b1000 || flags_q !== 4'b0001 || done !== 1'b1 || state !== 3'd4) begin
      errors++;
      $display("FAIL and_result: got res=%b flags=%b done=%b state=%0d want 1000 0001 1 4",
               res_q, flags_q, done, state);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL and_done_pulse: got done=%b want 0", done);
    end
    exp_res   = 4'b1000;
    exp_flags = 4'b0001;
  endtask

  task automatic test_sum_overflow();
    press(4'd0);
    press(4'b0111);
    press(4'b0001);
    press(4'b0011);
    @(negedge clk);
    checks++;
    if (res_q !== 4'b1000 || flags_q !== 4'b1001 || err !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL sum_overflow: got res=%b flags=%b err=%b done=%b want 1000 1001 0 1",
               res_q, flags_q, err, done);
    end
    exp_res   = 4'b1000;
    exp_flags = 4'b1001;
  endtask

  task automatic test_invalid_op();
    press(4'd0);
    press(4'b0100);
    press(4'b0010);
    press(4'b1111);
    checks++;
    if (err !== 1'b1 || state !== 3'd4 || done !== 1'b0 || sel !== 4'b1111) begin
      errors++;
      $display("FAIL invalid_op: got err=%b state=%0d done=%b sel=%b want 1 4 0 1111",
               err, state, done, sel);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || res_q !== exp_res || flags_q !== exp_flags || state !== 3'd4) begin
      errors++;
      $display("FAIL invalid_keep: got done=%b res=%b flags=%b state=%0d want 0 %b %b 4",
               done, res_q, flags_q, state, exp_res, exp_flags);
    end
  endtask

  task automatic test_held_button();
    press(4'd0);
    @(negedge clk);
    sw  = 4'b0110;
    btn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      sw = 4'b1001;
    end
    checks++;
    if (state !== 3'd1 || A !== 4'b0110 || B !== 4'b0010) begin
      errors++;
      $display("FAIL held_button: got state=%0d A=%b B=%b want 1 0110 0010", state, A, B);
    end
    btn = 1'b0;
    press(4'b0011);
    checks++;
    if (state !== 3'd2 || B !== 4'b0011) begin
      errors++;
      $display("FAIL held_release: got state=%0d B=%b want 2 0011", state, B);
    end
  endtask

  task automatic test_press_in_exec();
    // Still in S_OP from the previous test; A=0110, B=0011
    press(4'd1);
    btn = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 3'd4 || done !== 1'b1 || res_q !== 4'b0111) begin
      errors++;
      $display("FAIL exec_press: got state=%0d done=%b res=%b want 4 1 0111", state, done, res_q);
    end
    btn = 1'b0;
    idle(3);
    checks++;
    if (state !== 3'd4) begin
      errors++;
      $display("FAIL exec_press_not_queued: got state=%0d want 4", state);
    end
    exp_res   = 4'b0111;
    exp_flags = 4'b0000;
  endtask

  task automatic test_reset_mid_op();
    press(4'd0);
    press(4'b0101);
    checks++;
    if (state !== 3'd1 || A !== 4'b0101) begin
      errors++;
      $display("FAIL rst_mid_setup: got state=%0d A=%b want 1 0101", state, A);
    end
    @(negedge clk);
    rst = 1'b1;
    btn = 1'b1;
    #1;
    checks++;
    if (state !== 3'd0 || {A, B, sel, res_q, flags_q, done, err} !== 22'd0) begin
      errors++;
      $display("FAIL rst_async: got state=%0d A=%b res=%b flags=%b want all 0", state, A, res_q, flags_q);
    end
    @(negedge clk);
    rst = 1'b0;
    sw  = 4'b1110;
    idle(3);
    checks++;
    if (state !== 3'd0 || A !== 4'd0) begin
      errors++;
      $display("FAIL rst_held_btn: got state=%0d A=%b want 0 0000", state, A);
    end
    btn = 1'b0;
    press(4'b0011);
    checks++;
    if (state !== 3'd1 || A !== 4'b0011) begin
      errors++;
      $display("FAIL rst_after_repress: got state=%0d A=%b want 1 0011", state, A);
    end
  endtask

  task automatic test_random_ops();
    logic [3:0] a, b, op;
    logic [7:0] ref_v;
    do_reset();
    for (int t = 0; t < 25; t++) begin
      a  = 4'($urandom_range(0, 15));
      b  = 4'($urandom_range(0, 15));
      op = 4'($urandom_range(0, 15));
      idle($urandom_range(0, 3));
      press(a);
      idle($urandom_range(0, 3));
      press(b);
      idle($urandom_range(0, 3));
      press(op);
      if (op > 4'd9) begin
        checks++;
        if (state !== 3'd4 || err !== 1'b1 || done !== 1'b0 || res_q !== exp_res || flags_q !== exp_flags) begin
          errors++;
          $display("FAIL rand_invalid[%0d]: got state=%0d err=%b done=%b res=%b flags=%b want 4 1 0 %b %b",
                   t, state, err, done, res_q, flags_q, exp_res, exp_flags);
        end
      end else begin
        ref_v = alu_f(a, b, op);
        exp_res   = ref_v[3:0];
        exp_flags = ref_v[7:4];
        @(negedge clk);
        checks++;
        if (state !== 3'd4 || err !== 1'b0 || done !== 1'b1 || res_q !== exp_res ||
            flags_q !== exp_flags || {A, B, sel} !== {a, b, op}) begin
          errors++;
          $display("FAIL rand_exec[%0d]: got A=%b B=%b sel=%b res=%b flags=%b done=%b err=%b want %b %b %b %b %b 1 0",
                   t, A, B, sel, res_q, flags_q, done, err, a, b, op, exp_res, exp_flags);
        end
      end
      press(4'($urandom_range(0, 15)));
      checks++;
      if (state !== 3'd0) begin
        errors++;
        $display("FAIL rand_return[%0d]: got state=%0d want 0", t, state);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    btn       = 1'b0;
    sw        = 4'd0;
    exp_res   = 4'd0;
    exp_flags = 4'd0;
    test_reset();
    test_and();
    test_sum_overflow();
    test_invalid_op();
    test_held_button();
    test_press_in_exec();
    test_reset_mid_op();
    test_random_ops();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
